pu_or1k_pfpu64_cnv_ctrl: RTL
============================

# pu_or1k_pfpu64_cnv_ctrl

Issue and sequencing controller for the shared pfpu64 integer-to-float conversion pipe. It arbitrates between two requesters and drives the pipe's start, advance and flush controls. It tracks the id and tag of each in-flight operation across the pipe depth and applies write-back backpressure as a single global stall. It sits between the issue logic and the i2f/normalize/round chain of pfpu64.

## Interface
Parameters:
- DEPTH, 3, pipe stages from the i2f stage to the result (≥1)
- TAG_W, 4, width of the requester tag carried alongside each operation

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- flush_i  in  1  pipeline flush request
- req0_i / req1_i  in  1  requester 0/1 valid; held until granted
- opa0_i / opa1_i  in  64  requester 0/1 integer operand
- tag0_i / tag1_i  in  TAG_W  requester 0/1 tag
- gnt0_o / gnt1_o  out  1  grant; operand accepted this cycle
- pipe_start_o  out  1  start to the i2f stage
- pipe_adv_o  out  1  global advance to all pipe stages
- pipe_flush_o  out  1  flush to the pipe
- pipe_opa_o  out  64  selected operand to the i2f stage
- pipe_rdy_i  in  1  i2f stage ready flag, used for consistency checking
- out_vld_o  out  1  result valid at the last stage
- out_id_o  out  1  requester id of the result
- out_tag_o  out  TAG_W  tag of the result
- wb_rdy_i  in  1  write-back accepts the result
- occ_o  out  $clog2(DEPTH+1)  number of in-flight operations
- err_o  out  1  sticky tracker/pipe mismatch flag

## Operation
- Tracker: a DEPTH-entry shift register of {vld, id, tag}.
  - Entry 0 loads {start, granted id, granted tag} when pipe_adv_o=1.
  - Entry k loads entry k-1 when pipe_adv_o=1; nothing moves when pipe_adv_o=0.
- Outputs from the last tracker entry: out_vld_o = entry[DEPTH-1].vld; out_id_o and out_tag_o come from the same entry.
- pipe_adv_o = !out_vld_o | wb_rdy_i. It is combinational, and an empty pipe never stalls.
- Arbitration, all combinational:
  - Eligible only when pipe_adv_o=1 and flush_i=0.
  - At most one grant per cycle.
  - pipe_start_o = gnt0_o | gnt1_o.
  - pipe_opa_o = operand of the granted requester; opa0_i when there is no grant.
- Retire: a result retires when out_vld_o & wb_rdy_i.
- occ_o:
  - Increments on start without retire.
  - Decrements on retire without start.
  - Holds when both or neither occur.
  - Saturates neither way; the arithmetic guarantees 0..DEPTH.
- Flush: pipe_flush_o = flush_i, combinational.
  - On the clock edge with flush_i=1, all tracker vld bits and occ_o clear.
  - Grants are suppressed in that cycle.
  - A retire in the same cycle is still reported to write-back; flush wins on the state update.
- Consistency check: when pipe_adv_o was 1 on the previous edge and no flush occurred, entry[0].vld must equal pipe_rdy_i. On mismatch err_o sets and stays set until rst.
- Reset values:
  - All tracker entries invalid.
  - occ_o=0, err_o=0.
  - Round-robin pointer "last granted" = 1, so requester 0 wins first.
  - All combinational outputs follow from this reset state.

## Timing
- A grant in cycle N puts the operation in entry 0 at N+1 and asserts out_vld_o at N+DEPTH when there is no stall.
- Every stall cycle adds one cycle of latency. Throughput is one operation per cycle.
- Handshake: a requester keeps req/opa/tag stable until its grant. A grant is a same-cycle acceptance.
- Simultaneous retire and grant: allowed, occ_o unchanged.
- Full pipe with wb_rdy_i=0: pipe_adv_o=0, no grants, and all state holds.
- rst asserted mid-operation: all in-flight operations are discarded immediately (asynchronous). No out_vld_o appears after release until a new grant.

## Configuration
- PFPU64_CNV_RR_EN defined: round-robin arbitration.
  - When both requesters are eligible, the one that was not last granted wins.
  - The pointer updates on every grant.
- Not defined: fixed priority. req0_i always wins, and no pointer register exists.

## Test plan
- Single op: req0 with opa0=-5, tag0=3, DEPTH=3.
  - Required: gnt0 in cycle 0, out_vld_o in cycle 3 with id=0, tag=3, occ_o back to 0 in cycle 4.
- Back-to-back with both requesters always requesting, RR enabled.
  - Required: grants alternate 0,1,0,1; results emerge in the same order, one per cycle.
  - With the macro undefined: only gnt0 is ever issued.
- Backpressure: pipe full (occ_o=3) and wb_rdy_i=0 for 4 cycles.
  - Required: pipe_adv_o=0, no grants, out_tag_o stable.
  - On wb_rdy_i=1, results drain in order, one per cycle.
- Flush with 2 ops in flight and req1 pending.
  - Required: no grant in the flush cycle, occ_o=0 next cycle, and no stale out_vld_o.
  - req1 is granted in the following cycle.
- Mismatch: force pipe_rdy_i=0 after a granted start.
  - Required: err_o=1 on the next cycle, held until rst.
- Async reset mid-stream with 3 ops in flight.
  - Required: out_vld_o, occ_o and err_o drop to 0 immediately, and requester 0 wins the first grant after release.

Source files
------------

// File: rtl/pu_or1k_pfpu64_cnv_ctrl.sv
// pu_or1k_pfpu64_cnv_ctrl: issue/sequencing controller for the shared pfpu64 int-to-float pipe
// Ports: clk/rst (async, active-high); req*/opa*/tag*/gnt* requester handshakes;
//        pipe_start/adv/flush/opa drive the pipe, pipe_rdy_i cross-checks entry 0;
//        out_vld/id/tag report the last stage, wb_rdy_i stalls globally;
//        occ_o in-flight count, err_o sticky tracker/pipe mismatch.
// Define PFPU64_CNV_RR_EN for round-robin arbitration (default: requester 0 fixed priority).
module pu_or1k_pfpu64_cnv_ctrl #(
    parameter int DEPTH = 3,
    parameter int TAG_W = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush_i,
    input  logic                       req0_i,
    input  logic                       req1_i,
    input  logic [63:0]                opa0_i,
    input  logic [63:0]                opa1_i,
    input  logic [TAG_W-1:0]           tag0_i,
    input  logic [TAG_W-1:0]           tag1_i,
    output logic                       gnt0_o,
    output logic                       gnt1_o,
    output logic                       pipe_start_o,
    output logic                       pipe_adv_o,
    output logic                       pipe_flush_o,
    output logic [63:0]                pipe_opa_o,
    input  logic                       pipe_rdy_i,
    output logic                       out_vld_o,
    output logic                       out_id_o,
    output logic [TAG_W-1:0]           out_tag_o,
    input  logic                       wb_rdy_i,
    output logic [$clog2(DEPTH+1)-1:0] occ_o,
    output logic                       err_o
);
    localparam int OW = $clog2(DEPTH+1);

    logic [DEPTH-1:0] vld;
    logic [DEPTH-1:0] id;
    logic [TAG_W-1:0] tag [DEPTH];
    logic [OW-1:0]    occ;
    logic             err;
    logic             chk_q;
    logic             elig;
    logic             win0;
    logic             retire;

`ifdef PFPU64_CNV_RR_EN
    logic last;
    // requester 0 wins a tie only when requester 1 was granted last
    assign win0 = !req1_i || last;
    always_ff @(posedge clk or posedge rst)
        if (rst)
            last <= 1'b1;
        else if (pipe_start_o)
            last <= gnt1_o;
`else
    assign win0 = 1'b1;
`endif

    always_comb begin
        out_vld_o    = vld[DEPTH-1];
        out_id_o     = id[DEPTH-1];
        out_tag_o    = tag[DEPTH-1];
        pipe_adv_o   = !out_vld_o || wb_rdy_i;
        pipe_flush_o = flush_i;
        elig         = pipe_adv_o && !flush_i;
        gnt0_o       = elig && req0_i && win0;
        gnt1_o       = elig && req1_i && !gnt0_o;
        pipe_start_o = gnt0_o || gnt1_o;
        pipe_opa_o   = gnt1_o ? opa1_i : opa0_i;
        retire       = out_vld_o && wb_rdy_i;
        occ_o        = occ;
        err_o        = err;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld   <= '0;
            id    <= '0;
            for (int k = 0; k < DEPTH; k++) tag[k] <= '0;
            occ   <= '0;
            err   <= 1'b0;
            chk_q <= 1'b0;
        end else begin
            // entry 0 is only meaningful against the pipe after a real, unflushed advance
            err   <= err || (chk_q && (vld[0] != pipe_rdy_i));
            chk_q <= pipe_adv_o && !flush_i;
            if (flush_i) begin
                vld <= '0;
                occ <= '0;
            end else begin
                occ <= occ + OW'(pipe_start_o) - OW'(retire);
                if (pipe_adv_o) begin
                    for (int k = DEPTH-1; k > 0; k--) begin
                        vld[k] <= vld[k-1];
                        id[k]  <= id[k-1];
                        tag[k] <= tag[k-1];
                    end
                    vld[0] <= pipe_start_o;
                    id[0]  <= gnt1_o;
                    tag[0] <= gnt1_o ? tag1_i : tag0_i;
                end
            end
        end
    end
endmodule
